// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the 64-bit burst memory port between the icache and
// dcache. One line request at a time. A read is a 4-beat burst that is
// assembled into a 256-bit line. A write is a 4-beat burst taken from a
// latched line. Completion is a one-cycle resp pulse to the granted requester.
module bmem_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic [31:0]  icache_addr,
  input  logic         icache_read,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,

  input  logic [31:0]  dcache_addr,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,

  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                last_dc, last_dc_nx;   // 1: last grant went to dcache
  logic                id_dc, id_dc_nx;       // 1: current transfer belongs to dcache
  logic                op_wr, op_wr_nx;       // 1: current transfer is a write
  logic [LINE_W-1:0]   wline, wline_nx;
  logic [LINE_W-1:0]   line, line_nx;
  logic [31:0]         addr_nx;

  logic                i_pend;
  logic                d_pend;
  logic                grant_dc;

  // Offset bits select a byte within the line and play no part in the burst.
  logic                unused_offset_bits;
  assign unused_offset_bits = ^{icache_addr[OFFSET_W-1:0], dcache_addr[OFFSET_W-1:0]};

  // Pending requests and the round-robin tie-break toward the other requester.
  assign i_pend   = icache_read;
  assign d_pend   = dcache_read | dcache_write;
  assign grant_dc = d_pend & (~i_pend | ~last_dc);

  // Next-state, beat counter, latched request and line assembly.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    last_dc_nx = last_dc;
    id_dc_nx   = id_dc;
    op_wr_nx   = op_wr;
    wline_nx   = wline;
    line_nx    = line;
    addr_nx    = bmem_addr;

    case (state)
      IDLE: begin
        if (i_pend | d_pend) begin
          cnt_nx     = '0;
          id_dc_nx   = grant_dc;
          last_dc_nx = grant_dc;
          op_wr_nx   = grant_dc & dcache_write;
          addr_nx    = grant_dc ? {dcache_addr[31:OFFSET_W], OFFSET_W'(0)}
                                : {icache_addr[31:OFFSET_W], OFFSET_W'(0)};
          if (grant_dc & dcache_write) begin
            wline_nx = dcache_wdata;
            state_nx = WR_BURST;
          end else begin
            state_nx = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        if (bmem_ready) begin
          state_nx = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // Gap cycles (rvalid low) hold both the count and the partial line.
        if (bmem_rvalid) begin
          line_nx[{cnt, 6'b0} +: BEAT_W] = bmem_rdata;
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(3)) begin
            state_nx = RESP;
          end
        end
      end

      WR_BURST: begin
        if (bmem_ready) begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(3)) begin
            state_nx = RESP;
          end
        end
      end

      RESP: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter and request bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_dc <= 1'b0;
      id_dc   <= 1'b0;
      op_wr   <= 1'b0;
      wline   <= '0;
      line    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      last_dc <= last_dc_nx;
      id_dc   <= id_dc_nx;
      op_wr   <= op_wr_nx;
      wline   <= wline_nx;
      line    <= line_nx;
    end
  end

  // Memory-side outputs, registered from the next state so commands line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      bmem_addr  <= addr_nx;
      bmem_read  <= (state_nx == RD_ISSUE);
      bmem_write <= (state_nx == WR_BURST);
      bmem_wdata <= (state_nx == WR_BURST) ? wline_nx[{cnt_nx, 6'b0} +: BEAT_W]
                                           : BEAT_W'(0);
    end
  end

  // Requester-side responses; rdata updates only on a read completion and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icache_resp  <= 1'b0;
      dcache_resp  <= 1'b0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
    end else begin
      icache_resp <= (state_nx == RESP) & ~id_dc;
      dcache_resp <= (state_nx == RESP) &  id_dc;
      if ((state_nx == RESP) && !id_dc && !op_wr) begin
        icache_rdata <= line_nx;
      end
      if ((state_nx == RESP) && id_dc && !op_wr) begin
        dcache_rdata <= line_nx;
      end
    end
  end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Shares the single 64-bit burst memory port (bmem) between the instruction cache and the data cache. It accepts one line-sized request at a time, sequences the 4-beat read or write burst on bmem, and assembles read beats into a 256-bit line. It returns the line with a one-cycle response pulse to the requester that was granted. It sits between both caches and the memory model, replacing the standalone cacheline adapter on the read path.

## Interface
- No parameters. Line = 256 bits = 4 beats of 64 bits; address is 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- icache_addr  in  32  line address; bits [4:0] ignored.
- icache_read  in  1  read request; held high with stable address until icache_resp.
- icache_rdata  out  256  assembled line; valid while icache_resp=1.
- icache_resp  out  1  one-cycle completion pulse.
- dcache_addr  in  32  line address; bits [4:0] ignored.
- dcache_read  in  1  read request; held until dcache_resp.
- dcache_write  in  1  write request; held until dcache_resp.
- dcache_wdata  in  256  write line; held stable with dcache_write.
- dcache_rdata  out  256  assembled line; valid while dcache_resp=1.
- dcache_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  {latched_addr[31:5], 5'b0}.
- bmem_read  out  1  read command.
- bmem_write  out  1  write command, one per beat.
- bmem_wdata  out  64  current write beat.
- bmem_ready  in  1  memory accepts the command or beat this cycle.
- bmem_rdata  in  64  read beat.
- bmem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP.
- IDLE: pending requesters are icache (icache_read) and dcache (dcache_read|dcache_write).
  - If exactly one is pending, grant it.
  - If both are pending, grant the one that is not last_grant.
  - last_grant resets to ICACHE, so dcache wins the first tie.
- On grant, latch the requester ID, the address and the operation, and update last_grant.
  - dcache write: also latch dcache_wdata, then go to WR_BURST.
  - Any read: go to RD_ISSUE.
  - If dcache_read and dcache_write are both high, treat the request as a write.
- RD_ISSUE: drive bmem_read=1 and bmem_addr. On bmem_ready, go to RD_WAIT.
- RD_WAIT: each cycle with bmem_rvalid=1, store bmem_rdata into line[64*cnt +: 64] and increment the 2-bit cnt.
  - Beat 0 lands in bits [63:0].
  - Cycles with rvalid=0 are gaps: hold cnt and the stored data.
  - When the 4th beat is stored, go to RESP.
- WR_BURST: drive bmem_write=1, bmem_addr, and bmem_wdata = wline[64*cnt +: 64].
  - Increment cnt only on bmem_ready.
  - When beat 3 is accepted, go to RESP.
- RESP: pulse the granted requester's resp=1 for exactly one cycle. For reads, also drive its rdata = assembled line. Then go to IDLE.
- bmem_rvalid outside RD_WAIT is ignored.
- cnt clears on every grant.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, cnt=0, last_grant=ICACHE.
  - Every output is 0: resp, rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata.
  - Reset mid-burst abandons the transfer; no resp is issued.
- The grant is registered: a request seen in IDLE at edge N puts bmem_read or bmem_write high in the cycle after edge N.
- Read latency: resp is high in the cycle after the edge that captures the 4th rvalid beat.
  - Example: bmem_ready on the first issue cycle and 4 back-to-back beats gives resp in the 7th cycle after the request is first visible in IDLE.
- Write: bmem_write stays high for exactly 4 accepted beats. Its deassertion coincides with the resp pulse.
- bmem_read is high only in RD_ISSUE. bmem_read and bmem_write are never high together.
- rdata and resp outputs are registered; rdata holds its value outside resp.
- The requester drops its request in the resp cycle. The arbiter is in IDLE the next cycle and may grant a new request there, giving at least one idle bmem cycle between transactions.
- A request that arrives while the arbiter is busy waits; no request is dropped.

## Test plan
- Single icache read, icache_addr=0x1234_5678, bmem_ready=1, beats CAFEBABE14159265, DEADBEEF12345678, FECEBECE87654321, ABCDABCD12341234 -> bmem_addr=0x1234_5660, one bmem_read cycle, then icache_resp=1 for one cycle with icache_rdata = ABCDABCD12341234_FECEBECE87654321_DEADBEEF12345678_CAFEBABE14159265; dcache_resp stays 0.
- Same read with rvalid gaps (pattern 1,0,1,0,1,0,1) -> identical line; resp follows the 4th valid beat; data driven as 'x during the gaps has no effect.
- dcache write, wdata=256'h4444…_3333…_2222…_1111… (beats 0 to 3 = 64'h1111…, 2222…, 3333…, 4444…), bmem_ready toggling 1,0,1,1,0,1 -> exactly 4 accepted beats in order 1111, 2222, 3333, 4444; dcache_resp one cycle after the last accepted beat.
- Both caches request reads on the same cycle, repeatedly -> grant order D, I, D, I; each resp goes only to its own requester with the correct line.
- Assert rst during RD_WAIT after 2 beats, then release and issue a new icache read -> outputs clear immediately, no resp for the aborted read, and the new read returns a correct line starting from beat 0.
- Stray bmem_rvalid=1 while in IDLE and in WR_BURST -> no state or data change, no resp.
